// File: rtl/control_heroe.sv
// Hero pose/type controller feeding the glyph ROM.
// Edge-detected buttons start tick-timed poses; type advances only at rest.
module control_heroe #(
    parameter int unsigned TICK_DIV   = 12500000,
    parameter int unsigned DUR_SALTO  = 4,
    parameter int unsigned DUR_VUELO  = 8,
    parameter int unsigned DUR_AGACHE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_saltar,
    input  logic       btn_volar,
    input  logic       btn_agachar,
    input  logic       btn_tipo,
    output logic [2:0] tipo_h,
    output logic [1:0] var_h,
    output logic       ocupado
);

    localparam int unsigned CW  = $clog2(TICK_DIV);
    localparam int unsigned DM1 = (DUR_SALTO > DUR_VUELO) ? DUR_SALTO : DUR_VUELO;
    localparam int unsigned DM2 = (DM1 > DUR_AGACHE) ? DM1 : DUR_AGACHE;
    localparam int unsigned DW  = $clog2(DM2 + 2);

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        SALTO  = 2'd1,
        VUELO  = 2'd2,
        AGACHE = 2'd3
    } state_t;

    // A zero duration still holds the pose for one tick.
    function automatic logic [DW-1:0] dur_load(input int unsigned d);
        return (d == 0) ? DW'(1) : DW'(d);
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] rem_q, rem_d;
    logic [2:0]    tipo_q, tipo_d;
    logic          ocup_q, ocup_d;
    logic [3:0]    btn_q;
    logic [3:0]    btn_now;
    logic [3:0]    edge_w;
    logic          tick;

    assign btn_now = {btn_tipo, btn_agachar, btn_volar, btn_saltar};
    assign edge_w  = btn_now & ~btn_q;

    assign tick  = (cnt_q == CW'(TICK_DIV - 1));
    assign cnt_d = tick ? '0 : cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        tipo_d  = tipo_q;
        unique case (state_q)
            REPOSO: begin
                if (edge_w[1]) begin
                    state_d = VUELO;
                    rem_d   = dur_load(DUR_VUELO);
                end else if (edge_w[0]) begin
                    state_d = SALTO;
                    rem_d   = dur_load(DUR_SALTO);
                end else if (edge_w[2]) begin
                    state_d = AGACHE;
                    rem_d   = dur_load(DUR_AGACHE);
                end
                if (edge_w[3]) begin
                    tipo_d = (tipo_q >= 3'd4) ? 3'd0 : tipo_q + 3'd1;
                end
            end
            SALTO, VUELO, AGACHE: begin
                if (tick) begin
                    if (rem_q <= DW'(1)) begin
                        state_d = REPOSO;
                        rem_d   = '0;
                    end else begin
                        rem_d = rem_q - DW'(1);
                    end
                end
            end
            default: begin
                state_d = REPOSO;
                rem_d   = '0;
            end
        endcase
        ocup_d = (state_d != REPOSO);
    end

    // Edge registers reset high so a button held through reset is not a request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= REPOSO;
            cnt_q   <= '0;
            rem_q   <= '0;
            tipo_q  <= 3'd0;
            ocup_q  <= 1'b0;
            btn_q   <= 4'hF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            tipo_q  <= tipo_d;
            ocup_q  <= ocup_d;
            btn_q   <= btn_now;
        end
    end

    assign tipo_h  = tipo_q;
    assign var_h   = state_q;
    assign ocupado = ocup_q;

endmodule

// File: tb/tb_control_heroe.sv
// Scoreboard bench for control_heroe with a short tick period.
// Output changes are popped against expected value and edge number.
module tb_control_heroe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bs = 1'b0, bv = 1'b0, ba = 1'b0, bt = 1'b0;
    logic [2:0] tipo_h;
    logic [1:0] var_h;
    logic       ocupado;

    int         ecnt;
    int         nchk = 0;
    int         nerr = 0;
    bit         mon_en = 1'b0;
    logic [5:0] last;

    typedef struct {
        int         edg;
        logic [5:0] val;
    } exp_t;

    exp_t  sb[$];
    string sbn[$];

    always #5 clk = ~clk;

    control_heroe #(
        .TICK_DIV  (4),
        .DUR_SALTO (2),
        .DUR_VUELO (3),
        .DUR_AGACHE(1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_saltar (bs),
        .btn_volar  (bv),
        .btn_agachar(ba),
        .btn_tipo   (bt),
        .tipo_h     (tipo_h),
        .var_h      (var_h),
        .ocupado    (ocupado)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    always @(negedge clk) begin
        logic [5:0] cur;
        exp_t       e;
        string      n;
        cur = {tipo_h, var_h, ocupado};
        if (mon_en && cur !== last) begin
            last = cur;
            nchk++;
            if (sb.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_change: got %h at edge %0d, required no change",
                         cur, ecnt);
            end else begin
                e = sb.pop_front();
                n = sbn.pop_front();
                if (cur !== e.val || (e.edg >= 0 && e.edg != ecnt)) begin
                    nerr++;
                    $display("FAIL %s: got %h at edge %0d, required %h at edge %0d",
                             n, cur, ecnt, e.val, e.edg);
                end
            end
        end
    end

    task automatic push(input string n, input int e,
                        input logic [2:0] t, input logic [1:0] v, input logic o);
        exp_t x;
        x.edg = e;
        x.val = {t, v, o};
        sb.push_back(x);
        sbn.push_back(n);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string n, input logic [5:0] got, input logic [5:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %h, required %h", n, got, want);
        end
    endtask

    // Edge at which the pose ends: ticks land on edges that are multiples of 4.
    function automatic int ret_edge(input int p, input int d);
        return (p / 4 + 1) * 4 + 4 * (d - 1);
    endfunction

    int p, r;

    initial begin
        #1;
        check("reset_state", {tipo_h, var_h, ocupado}, 6'h00);
        cyc(2);
        rst_n = 1'b1;
        last = 6'h00;
        mon_en = 1'b1;
        cyc(3);

        // held jump: one action only
        p = ecnt + 1;
        bs = 1'b1;
        push("jump_on", p, 3'd0, 2'd1, 1'b1);
        push("jump_off", ret_edge(p, 2), 3'd0, 2'd0, 1'b0);
        cyc(20);
        bs = 1'b0;
        cyc(4);

        // volar beats saltar
        p = ecnt + 1;
        bv = 1'b1;
        bs = 1'b1;
        push("prio_on", p, 3'd0, 2'd2, 1'b1);
        push("prio_off", ret_edge(p, 3), 3'd0, 2'd0, 1'b0);
        cyc(1);
        bv = 1'b0;
        bs = 1'b0;
        cyc(16);

        // agachar during vuelo ignored
        p = ecnt + 1;
        bv = 1'b1;
        push("busy_on", p, 3'd0, 2'd2, 1'b1);
        push("busy_off", ret_edge(p, 3), 3'd0, 2'd0, 1'b0);
        cyc(1);
        bv = 1'b0;
        cyc(1);
        ba = 1'b1;
        cyc(1);
        ba = 1'b0;
        cyc(14);

        // type wrap 1,2,3,4,0
        for (int k = 1; k <= 5; k++) begin
            p = ecnt + 1;
            bt = 1'b1;
            push("tipo_step", p, 3'(k % 5), 2'd0, 1'b0);
            cyc(1);
            bt = 1'b0;
            cyc(1);
        end
        cyc(2);

        // tipo during salto ignored
        p = ecnt + 1;
        bs = 1'b1;
        push("tipo_busy_on", p, 3'd0, 2'd1, 1'b1);
        push("tipo_busy_off", ret_edge(p, 2), 3'd0, 2'd0, 1'b0);
        cyc(1);
        bs = 1'b0;
        bt = 1'b1;
        cyc(1);
        bt = 1'b0;
        cyc(10);

        // tipo + agachar together, then saltar edge on the return cycle
        p = ecnt + 1;
        bt = 1'b1;
        ba = 1'b1;
        r = ret_edge(p, 1);
        push("both_on", p, 3'd1, 2'd3, 1'b1);
        push("both_off", r, 3'd1, 2'd0, 1'b0);
        cyc(1);
        bt = 1'b0;
        ba = 1'b0;
        while (ecnt < r - 1) cyc(1);
        bs = 1'b1;
        cyc(4);
        bs = 1'b0;
        cyc(4);

        // reset mid-vuelo with volar held through release
        p = ecnt + 1;
        bv = 1'b1;
        push("rst_vuelo_on", p, 3'd1, 2'd2, 1'b1);
        cyc(2);
        @(posedge clk);
        #2;
        push("rst_abort", -1, 3'd0, 2'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_async", {tipo_h, var_h, ocupado}, 6'h00);
        cyc(2);
        rst_n = 1'b1;
        cyc(10);
        bv = 1'b0;
        cyc(1);
        p = ecnt + 1;
        bv = 1'b1;
        push("post_rst_on", p, 3'd0, 2'd2, 1'b1);
        push("post_rst_off", ret_edge(p, 3), 3'd0, 2'd0, 1'b0);
        cyc(1);
        bv = 1'b0;
        cyc(16);

        while (sb.size() != 0) begin
            exp_t  e;
            string n;
            e = sb.pop_front();
            n = sbn.pop_front();
            nchk++;
            nerr++;
            $display("FAIL %s: got no change, required %h at edge %0d", n, e.val, e.edg);
        end
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/control_heroe.md
CONTROL_HEROE -- requirements
Module: control_heroe

Interface
REQ-001 Parameter TICK_DIV, default 12500000: clk cycles per action tick (4 Hz at 50 MHz); legal range >= 2.
REQ-002 Parameter DUR_SALTO, default 4: length of the jump pose, in ticks.
REQ-003 Parameter DUR_VUELO, default 8: length of the fly pose, in ticks.
REQ-004 Parameter DUR_AGACHE, default 4: length of the crouch pose, in ticks.
REQ-005 clk  input  1  single system clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 btn_saltar  input  1  jump request; level, already synchronous to clk.
REQ-008 btn_volar  input  1  fly request; level, synchronous.
REQ-009 btn_agachar  input  1  crouch request; level, synchronous.
REQ-010 btn_tipo  input  1  hero-type advance request; level, synchronous.
REQ-011 tipo_h  output  3  hero type to the glyph ROM; 0=U, 1=I, 2=P, 3=F, 4=E.
REQ-012 var_h  output  2  pose to the glyph ROM; 0=rest, 1=jump, 2=fly, 3=crouch.
REQ-013 ocupado  output  1  high while any action pose is active.

Function
REQ-014 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.
REQ-015 Each button SHALL be rising-edge detected with its own previous-value register; only a 0->1 transition counts as a request, and holding a button SHALL NOT retrigger.
REQ-016 Tick generator: free-running counter 0..TICK_DIV-1; tick is a one-cycle pulse in the cycle the counter equals TICK_DIV-1, after which the counter wraps to 0.
REQ-017 FSM states and var_h encoding: REPOSO (var_h=0), SALTO (1), VUELO (2), AGACHE (3).
REQ-018 In REPOSO, an action-button edge in cycle n SHALL move the FSM to the matching state, with var_h and ocupado updated at the clk edge that ends cycle n (1-cycle latency).
REQ-019 Simultaneous action edges in REPOSO SHALL be resolved with priority volar > saltar > agachar; the losing requests SHALL be discarded, not queued.
REQ-020 On entry to an action state, a remaining-tick counter SHALL load the matching DUR_*; a DUR_* value of 0 SHALL load as 1.
REQ-021 A tick that coincides with the entry cycle SHALL NOT be counted.
REQ-022 Each later tick SHALL decrement the remaining count; the tick that finds it at 1 SHALL return the FSM to REPOSO on the next clk edge, so var_h=0 and ocupado=0.
REQ-023 Action-button edges that arrive during an action state SHALL be ignored; there are no aborts and no chaining.
REQ-024 An action-button edge in the same cycle as the return to REPOSO SHALL be ignored; a new action needs an edge while the FSM is already in REPOSO.
REQ-025 A btn_tipo edge in REPOSO SHALL set tipo_h to tipo_h+1, wrapping 4->0, with 1-cycle latency.
REQ-026 A btn_tipo edge during an action state SHALL be ignored, so tipo_h is constant for the whole action.
REQ-027 A btn_tipo edge and an action edge in the same REPOSO cycle SHALL both take effect.
REQ-028 tipo_h SHALL always hold 0..4; values 5..7 SHALL never be produced.
REQ-029 ocupado SHALL equal (state != REPOSO), registered.

Reset
REQ-030 While rst_n=0, asynchronously: state=REPOSO, tipo_h=0, var_h=0, ocupado=0, tick counter=0, remaining-tick counter=0.
REQ-031 While rst_n=0, all edge-detect registers SHALL be set to 1, so a button already held high at reset release does not trigger.
REQ-032 Reset asserted mid-action SHALL abort the action immediately; after release the block SHALL run normally from REPOSO with no residual tick phase.

Verification (TICK_DIV=4, DUR_SALTO=2, DUR_VUELO=3, DUR_AGACHE=1)
REQ-033 Jump: btn_saltar rises in REPOSO -> next cycle var_h=1, ocupado=1; var_h=0 the cycle after the 2nd counted tick; total 5..8 cycles depending on tick phase.
REQ-034 Priority: btn_volar and btn_saltar rise together -> var_h=2, held 3 counted ticks; the jump is never taken afterward.
REQ-035 Busy ignore: btn_agachar rises during VUELO -> var_h stays 2 and its duration is unchanged; after return to REPOSO, var_h=0.
REQ-036 Type wrap: five btn_tipo pulses in REPOSO -> tipo_h steps 1,2,3,4,0; one pulse during SALTO -> tipo_h unchanged.
REQ-037 Reset: rst_n low during VUELO -> outputs 0 with no clk edge; btn_volar held high through release -> no action until it falls and rises again.
REQ-038 Hold: btn_saltar held high for 20 cycles -> exactly one jump.
